// File: rtl/clk_heartbeat_monitor.sv
// Heartbeat liveness monitor: measures rise-to-rise period of each asynchronous
// heartbeat bit in local clk cycles, flags channels alive/dead, and drives status LEDs.
module clk_heartbeat_monitor #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 28,
    parameter int unsigned TIMEOUT  = 62_500_000,
    parameter int unsigned BLINK_W  = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            hb_in,
    output logic [NUM_CH-1:0]            ch_alive,
    output logic [NUM_CH-1:0]            ch_dead,
    output logic [NUM_CH*PERIOD_W-1:0]   ch_period,
    output logic [NUM_CH-1:0]            period_valid,
    output logic [1:0]                   led_out
);

    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
    localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
    localparam logic [BLINK_W-1:0]  BLINK_ONE = BLINK_W'(1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ALIVE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    logic [NUM_CH-1:0]  alive_d;
    logic [NUM_CH-1:0]  dead_d;
    logic [NUM_CH-1:0]  alive_q;
    logic [NUM_CH-1:0]  dead_q;
    logic [BLINK_W-1:0] blink_q;
    logic [BLINK_W-1:0] blink_d;
    logic [1:0]         led_q;
    logic [1:0]         led_d;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        logic                s1_q;
        logic                s2_q;
        logic                s3_q;
        logic                rise_q;
        logic [PERIOD_W-1:0] cnt_q;
        logic [PERIOD_W-1:0] cnt_d;
        logic [PERIOD_W-1:0] period_q;
        logic [PERIOD_W-1:0] period_d;
        logic                pv_q;
        logic                pv_d;
        logic                timeout;
        state_t              state_q;
        state_t              state_d;

        // Two-flop synchroniser, edge-detect delay flop, and a registered rise pulse
        // so counter/state updates land three edges after s1 first samples the edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q   <= 1'b0;
                s2_q   <= 1'b0;
                s3_q   <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                s1_q   <= hb_in[g];
                s2_q   <= s1_q;
                s3_q   <= s2_q;
                rise_q <= s2_q & ~s3_q;
            end
        end

        assign timeout = (cnt_q >= TIMEOUT_C);

        // Next-state: a rise always beats a timeout landing on the same cycle.
        always_comb begin
            state_d  = state_q;
            period_d = period_q;
            pv_d     = 1'b0;
            cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            if (rise_q) begin
                cnt_d = CNT_ONE;
            end
            case (state_q)
                ST_INIT: begin
                    if (rise_q) begin
                        state_d = ST_ARMED;
                    end else if (timeout) begin
                        state_d = ST_DEAD;
                    end
                end
                ST_ARMED, ST_ALIVE: begin
                    if (rise_q) begin
                        state_d  = ST_ALIVE;
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                    end else if (timeout) begin
                        state_d = ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    if (rise_q) begin
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_INIT;
                cnt_q    <= '0;
                period_q <= '0;
                pv_q     <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                period_q <= period_d;
                pv_q     <= pv_d;
            end
        end

        assign alive_d[g]                           = (state_d == ST_ALIVE);
        assign dead_d[g]                            = (state_d == ST_DEAD);
        assign ch_period[g*PERIOD_W +: PERIOD_W]    = period_q;
        assign period_valid[g]                      = pv_q;
    end

    // Status flags and LEDs are loaded from next-state so they track the FSMs exactly.
    assign blink_d = blink_q + BLINK_ONE;
    assign led_d   = {(|dead_d) & blink_d[BLINK_W-1], &alive_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= '0;
            dead_q  <= '0;
            blink_q <= '0;
            led_q   <= '0;
        end else begin
            alive_q <= alive_d;
            dead_q  <= dead_d;
            blink_q <= blink_d;
            led_q   <= led_d;
        end
    end

    assign ch_alive = alive_q;
    assign ch_dead  = dead_q;
    assign led_out  = led_q;

endmodule
